ex_mem_skid: RTL and testbench

//   EX->MEM pipeline register with valid/ready handshake and 2-entry skid storage.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/pipe_skid_buf.sv | 84 ++++++++
 rtl/ex_mem_skid.sv | 85 ++++++++
 tb/tb_ex_mem_skid.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the pipeline-stage registers.
//   EX_DATA_W / EX_ADDR_W : payload widths of the EX->MEM beat
//   ex_mem_t              : EX->MEM beat {wdata, waddr, wreg}
//   REG_ZERO              : index of the hard-wired zero register
package cpu_pkg;

  localparam int unsigned EX_DATA_W = 32;
  localparam int unsigned EX_ADDR_W = 5;

  typedef struct packed {
    logic [EX_DATA_W-1:0] wdata;
    logic [EX_ADDR_W-1:0] waddr;
    logic                 wreg;
  } ex_mem_t;

  localparam logic [EX_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer over payload type T.
//   clk_i        clock
//   rst_i        synchronous active-high reset (clears valids and payloads)
//   clr_i        clears both valids; payloads keep stale contents
//   valid_i      upstream beat valid
//   ready_o      registered ready (= SKID empty)
//   data_i       upstream payload
//   valid_o      OUT valid
//   ready_i      downstream ready
//   data_o       OUT payload
//   skid_valid_o SKID valid (tap)
//   skid_data_o  SKID payload (tap)
module pipe_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic skid_valid_o,
  output T     skid_data_o
);

  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  T     out_data_q, out_data_d;
  T     skid_data_q, skid_data_d;
  logic accept, drain;

  assign ready_o      = ~skid_valid_q;
  assign valid_o      = out_valid_q;
  assign data_o       = out_data_q;
  assign skid_valid_o = skid_valid_q;
  assign skid_data_o  = skid_data_q;

  assign accept = valid_i & ready_o;
  assign drain  = out_valid_q & ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        // SKID is older than any new beat, so it moves to OUT first.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) skid_data_d = data_i;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = data_i;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
    if (clr_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline register with valid/ready handshake and
// 2-entry skid storage, flush, and zero-register write masking.
//   clk_i, rst_i (sync, active-high), flush_i
//   valid_i/ready_o/wdata_i/waddr_i/wreg_i : EX side (ready_o registered)
//   valid_o/ready_i/wdata_o/waddr_o/wreg_o : MEM side
// Optional feature macro EX_MEM_FWD_EN adds forwarding taps
//   fwd_we_o/fwd_waddr_o/fwd_wdata_o exposing the youngest held valid beat.
// DATA_W/ADDR_W must match the widths of cpu_pkg::ex_mem_t.
module ex_mem_skid
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = EX_DATA_W,
  parameter int unsigned ADDR_W = EX_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              wreg_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              wreg_o
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_we_o,
  output logic [ADDR_W-1:0] fwd_waddr_o,
  output logic [DATA_W-1:0] fwd_wdata_o
`endif
);

  ex_mem_t in_beat, out_beat, skid_beat;
  logic    skid_valid;

  always_comb begin
    in_beat       = '0;
    in_beat.wdata = wdata_i;
    in_beat.waddr = waddr_i;
    in_beat.wreg  = wreg_i & (waddr_i != REG_ZERO);
  end

  pipe_skid_buf #(
    .T (ex_mem_t)
  ) u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (in_beat),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (out_beat),
    .skid_valid_o (skid_valid),
    .skid_data_o  (skid_beat)
  );

  assign wdata_o = out_beat.wdata;
  assign waddr_o = out_beat.waddr;
  // Flush leaves stale payload behind; gating with valid keeps wreg_o low.
  assign wreg_o  = out_beat.wreg & valid_o;

`ifdef EX_MEM_FWD_EN
  always_comb begin
    fwd_we_o    = 1'b0;
    fwd_waddr_o = out_beat.waddr;
    fwd_wdata_o = out_beat.wdata;
    if (skid_valid) begin
      fwd_we_o    = skid_beat.wreg;
      fwd_waddr_o = skid_beat.waddr;
      fwd_wdata_o = skid_beat.wdata;
    end else if (valid_o) begin
      fwd_we_o = out_beat.wreg;
    end
  end
`else
  logic unused_skid;
  assign unused_skid = skid_valid ^ (^skid_beat);
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i, wreg_i;
  logic        ready_o, valid_o, wreg_o;
  logic [31:0] wdata_i, wdata_o;
  logic [4:0]  waddr_i, waddr_o;
`ifdef EX_MEM_FWD_EN
  logic        fwd_we_o;
  logic [4:0]  fwd_waddr_o;
  logic [31:0] fwd_wdata_o;
`endif

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_skid #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .wdata_i (wdata_i),
    .waddr_i (waddr_i),
    .wreg_i  (wreg_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .wdata_o (wdata_o),
    .waddr_o (waddr_o),
    .wreg_o  (wreg_o)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_we_o    (fwd_we_o),
    .fwd_waddr_o (fwd_waddr_o),
    .fwd_wdata_o (fwd_wdata_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a, input logic w);
    valid_i = v;
    wdata_i = d;
    waddr_i = a;
    wreg_i  = w;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic w);
    chk({tag, ".valid"}, 64'(valid_o), 64'(v));
    chk({tag, ".wdata"}, 64'(wdata_o), 64'(d));
    chk({tag, ".waddr"}, 64'(waddr_o), 64'(a));
    chk({tag, ".wreg"},  64'(wreg_o),  64'(w));
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);

    // 1 reset
    tick(); tick();
    rst_i = 1'b0;
    chk_out("reset", 1'b0, 32'h0, 5'd0, 1'b0);
    chk("reset.ready", 64'(ready_o), 64'd1);

    // 2 streaming
    ready_i = 1'b1;
    drive(1'b1, 32'h11, 5'd3, 1'b1); tick();
    chk_out("str1", 1'b1, 32'h11, 5'd3, 1'b1);
    chk("str1.ready", 64'(ready_o), 64'd1);
    drive(1'b1, 32'h22, 5'd4, 1'b1); tick();
    chk_out("str2", 1'b1, 32'h22, 5'd4, 1'b1);
    chk("str2.ready", 64'(ready_o), 64'd1);
    drive(1'b1, 32'h33, 5'd5, 1'b1); tick();
    chk_out("str3", 1'b1, 32'h33, 5'd5, 1'b1);
    chk("str3.ready", 64'(ready_o), 64'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();
    chk("str.empty", 64'(valid_o), 64'd0);

    // 3 stall: A to OUT, B to SKID, C held off
    ready_i = 1'b0;
    drive(1'b1, 32'hA1, 5'd1, 1'b1); tick();
    chk_out("stA", 1'b1, 32'hA1, 5'd1, 1'b1);
    chk("stA.ready", 64'(ready_o), 64'd1);
    drive(1'b1, 32'hB2, 5'd2, 1'b0); tick();
    chk_out("stB", 1'b1, 32'hA1, 5'd1, 1'b1);
    chk("stB.ready", 64'(ready_o), 64'd0);
    drive(1'b1, 32'hC3, 5'd6, 1'b1); tick();
    chk_out("stC.hold", 1'b1, 32'hA1, 5'd1, 1'b1);
    chk("stC.ready", 64'(ready_o), 64'd0);
    ready_i = 1'b1; tick();
    chk_out("rel.B", 1'b1, 32'hB2, 5'd2, 1'b0);
    chk("rel.ready", 64'(ready_o), 64'd1);
    tick();
    chk_out("rel.C", 1'b1, 32'hC3, 5'd6, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();
    chk("rel.empty", 64'(valid_o), 64'd0);

    // 4 zero register
    drive(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1); tick();
    chk_out("zero", 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();

    // 5 flush while full with an incoming beat
    ready_i = 1'b0;
    drive(1'b1, 32'h51, 5'd1, 1'b1); tick();
    drive(1'b1, 32'h52, 5'd2, 1'b1); tick();
    chk("fl.full", 64'(ready_o), 64'd0);
    flush_i = 1'b1;
    drive(1'b1, 32'h5D, 5'd9, 1'b1); tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("fl.valid", 64'(valid_o), 64'd0);
    chk("fl.ready", 64'(ready_o), 64'd1);
    chk("fl.wreg", 64'(wreg_o), 64'd0);
    ready_i = 1'b1; tick();
    chk("fl.after1", 64'(valid_o), 64'd0);
    tick();
    chk("fl.after2", 64'(valid_o), 64'd0);
    drive(1'b1, 32'h5E, 5'd10, 1'b1); tick();
    chk_out("fl.next", 1'b1, 32'h5E, 5'd10, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();

    // reset mid-stall together with flush: both beats lost
    ready_i = 1'b0;
    drive(1'b1, 32'h61, 5'd1, 1'b1); tick();
    drive(1'b1, 32'h62, 5'd2, 1'b1); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    rst_i = 1'b1; flush_i = 1'b1; tick();
    rst_i = 1'b0; flush_i = 1'b0;
    chk_out("rstmid", 1'b0, 32'h0, 5'd0, 1'b0);
    chk("rstmid.ready", 64'(ready_o), 64'd1);
    ready_i = 1'b1; tick();
    chk("rstmid.none", 64'(valid_o), 64'd0);

`ifdef EX_MEM_FWD_EN
    // 6 forwarding taps
    chk("fwd.idle", 64'(fwd_we_o), 64'd0);
    ready_i = 1'b0;
    drive(1'b1, 32'h5, 5'd7, 1'b1); tick();
    chk("fwdA.waddr", 64'(fwd_waddr_o), 64'd7);
    chk("fwdA.wdata", 64'(fwd_wdata_o), 64'h5);
    chk("fwdA.we", 64'(fwd_we_o), 64'd1);
    drive(1'b1, 32'h9, 5'd7, 1'b1); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("fwdB.waddr", 64'(fwd_waddr_o), 64'd7);
    chk("fwdB.wdata", 64'(fwd_wdata_o), 64'h9);
    chk("fwdB.we", 64'(fwd_we_o), 64'd1);
    chk("fwdB.out", 64'(wdata_o), 64'h5);
    flush_i = 1'b1; tick();
    flush_i = 1'b0;
    chk("fwd.flush", 64'(fwd_we_o), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
